aes_out_serializer: RTL
=======================

Name: aes_out_serializer

Overview:
Upstream neighbour of fifo_data_out. Accepts one 128-bit AES result block per valid/ready handshake from the cipher core. Splits the block into four 32-bit words and writes them, one per clock, into the output FIFO's write port. Honours the FIFO's full flag and stalls word-by-word until space is available.

Parameters:
DATA_IN_WH, 128, width of the block from the cipher core
WORD_WH, 32, FIFO word width; DATA_IN_WH must be an integer multiple of WORD_WH
MSW_FIRST, 1, 1: bits [127:96] are sent first; 0: bits [31:0] are sent first
BYTE_SWAP, 0, 1: reverse the byte order inside each word before output
CNT_WH, 16, width of the completed-block counter

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
blk_valid  in  1  cipher core presents a block
blk_data  in  DATA_IN_WH  block payload, valid while blk_valid is high
blk_ready  out  1  serializer accepts a block this cycle
full_fifo  in  1  full flag from fifo_data_out
write_fifo  out  1  write strobe to fifo_data_out
data_out  out  WORD_WH  word to fifo_data_out data_in
busy  out  1  a block is held or being sent
word_idx  out  2  index of the word currently presented (0..NWORDS-1)
blk_count  out  CNT_WH  number of fully written blocks, wraps

Behaviour:
- NWORDS = DATA_IN_WH/WORD_WH (4 by default). Reset is asynchronous active-low; clk and resetn are the only clock and reset.
- Reset values: state=IDLE; block register=0; word_idx=0; blk_count=0; busy=0; write_fifo=0; blk_ready=1 (IDLE); data_out=0.
- FSM states:
  - IDLE: blk_ready=1. When blk_valid=1 at a clock edge, capture blk_data, set word_idx=0, go to SEND.
  - SEND: data_out = the word selected by word_idx (order set by MSW_FIRST, swap set by BYTE_SWAP). write_fifo = !full_fifo (combinational). On an edge with write_fifo=1:
    - if word_idx < NWORDS-1, word_idx increments;
    - on the last word, blk_count increments.
- Last-word transition:
  - if blk_valid=1 and blk_ready=1, capture the new block, set word_idx=0 and stay in SEND (back-to-back);
  - otherwise go to IDLE.
- blk_ready = (state==IDLE) || (state==SEND && word_idx==NWORDS-1 && !full_fifo). This is a combinational path from full_fifo; it is accepted.
- Latency: a block accepted at edge N has its first word written at edge N+1 if not full. Four words are written at edges N+1..N+4 with no stalls. Sustained throughput is one word per clock with no bubble between blocks.
- full_fifo stall: write_fifo never asserts while full_fifo=1. This is mandatory because the FIFO counter misbehaves on a write attempt while full. data_out and word_idx hold during a stall.
- read_fifo is not driven here. A simultaneous FIFO read does not change this block's behaviour within the same cycle; full_fifo is sampled as presented.
- busy = (state==SEND).
- blk_count wraps from 2^CNT_WH-1 to 0.
- Reset mid-block: the partial block is discarded and write_fifo drops immediately, asynchronously. Words already written remain the FIFO's responsibility; the FIFO resets synchronously on the same resetn.
- blk_data is sampled only at the acceptance edge. Changes to blk_data while in SEND have no effect.

Decomposition:
- Shared header holds DATA_IN_WH/WORD_WH defaults (128/32), the NWORDS derivation and the FSM state encodings (IDLE=1'b0, SEND=1'b1). These are shared with fifo_data_out and the top level.
- The word select/byte-swap logic is a natural single sub-module, aes_word_select (combinational mux with MSW_FIRST/BYTE_SWAP). The FSM, counters and block register stay in aes_out_serializer.

Test Plan:
- Basic send:
  - Stimulus: block 0x00112233_44556677_8899AABB_CCDDEEFF, MSW_FIRST=1, full_fifo=0.
  - Response: write_fifo high for 4 consecutive cycles; data_out = 00112233, 44556677, 8899AABB, CCDDEEFF; blk_count 0->1; busy low after.
- Order and swap:
  - Stimulus: same block with MSW_FIRST=0, BYTE_SWAP=1.
  - Response: words FFEEDDCC, BBAA9988, 77665544, 33221100.
- Stall:
  - Stimulus: full_fifo held high for 3 cycles after word 1 is written.
  - Response: write_fifo=0 for those 3 cycles; data_out holds 44556677; completion 3 cycles late; exactly 4 writes total.
- Back-to-back:
  - Stimulus: blk_valid held high with two blocks, A then B.
  - Response: 8 writes on 8 consecutive edges; blk_ready pulses on the last-word cycle of A; blk_count=2.
- Full on last word:
  - Stimulus: full_fifo=1 during word 3.
  - Response: blk_ready=0 and the next block is not accepted until full_fifo drops.
- Reset mid-block:
  - Stimulus: resetn low after word 1.
  - Response: write_fifo, busy and blk_count go to 0 immediately; blk_ready=1 after release; the next block starts at word 0.

Source files
------------

// File: rtl/aes_out_serializer_pkg.sv
// rtl/aes_out_serializer_pkg.sv - shared widths, word count and FSM encoding for the AES output path
package aes_out_serializer_pkg;

    localparam int DATA_IN_WH_DEF = 128;
    localparam int WORD_WH_DEF    = 32;

    function automatic int nwords(input int data_wh, input int word_wh);
        return data_wh / word_wh;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/aes_word_select.sv
// rtl/aes_word_select.sv - picks one word of the held AES block, with selectable order and byte swap
module aes_word_select
    import aes_out_serializer_pkg::*;
#(
    parameter int DATA_IN_WH = DATA_IN_WH_DEF,
    parameter int WORD_WH    = WORD_WH_DEF,
    parameter int MSW_FIRST  = 1,
    parameter int BYTE_SWAP  = 0
) (
    input  logic [DATA_IN_WH-1:0] blk,
    input  logic [1:0]            idx,
    output logic [WORD_WH-1:0]    word
);

    localparam int NWORDS = nwords(DATA_IN_WH, WORD_WH);
    localparam int NBYTES = WORD_WH / 8;

    always_comb begin
        int pos;
        logic [WORD_WH-1:0] raw;
        pos  = (MSW_FIRST != 0) ? (NWORDS - 1 - int'(idx)) : int'(idx);
        raw  = blk[pos*WORD_WH +: WORD_WH];
        word = raw;
        if (BYTE_SWAP != 0) begin
            for (int b = 0; b < NBYTES; b++) begin
                word[b*8 +: 8] = raw[(NBYTES-1-b)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/aes_out_serializer.sv
// rtl/aes_out_serializer.sv - splits accepted AES blocks into words written to the output FIFO
module aes_out_serializer
    import aes_out_serializer_pkg::*;
#(
    parameter int DATA_IN_WH = DATA_IN_WH_DEF,
    parameter int WORD_WH    = WORD_WH_DEF,
    parameter int MSW_FIRST  = 1,
    parameter int BYTE_SWAP  = 0,
    parameter int CNT_WH     = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  blk_valid,
    input  logic [DATA_IN_WH-1:0] blk_data,
    output logic                  blk_ready,
    input  logic                  full_fifo,
    output logic                  write_fifo,
    output logic [WORD_WH-1:0]    data_out,
    output logic                  busy,
    output logic [1:0]            word_idx,
    output logic [CNT_WH-1:0]     blk_count
);

    localparam int         NWORDS   = nwords(DATA_IN_WH, WORD_WH);
    localparam logic [1:0] LAST_IDX = 2'(NWORDS - 1);

    ser_state_t              state_q, state_d;
    logic [DATA_IN_WH-1:0]   blk_q, blk_d;
    logic [1:0]              idx_q, idx_d;
    logic [CNT_WH-1:0]       cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            blk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write strobe and ready are combinational on full_fifo so a full FIFO is never written.
    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        busy       = (state_q == SEND);
        write_fifo = (state_q == SEND) && !full_fifo;
        blk_ready  = (state_q == IDLE) ||
                     ((state_q == SEND) && (idx_q == LAST_IDX) && !full_fifo);
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    blk_d   = blk_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (write_fifo) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        idx_d = '0;
                        if (blk_valid) begin
                            blk_d = blk_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    aes_word_select #(
        .DATA_IN_WH (DATA_IN_WH),
        .WORD_WH    (WORD_WH),
        .MSW_FIRST  (MSW_FIRST),
        .BYTE_SWAP  (BYTE_SWAP)
    ) u_word_select (
        .blk  (blk_q),
        .idx  (idx_q),
        .word (data_out)
    );

    assign word_idx  = idx_q;
    assign blk_count = cnt_q;

endmodule
